// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction-memory responder: valid/ready fetch with programmable wait states
// Build option: define ADDR_ERR_EN to flag misaligned or out-of-range fetch addresses.
module inst_mem_responder #(
    parameter int MEM_BYTES   = 64,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instruction,
    output logic        resp_error,
    input  logic        load_en,
    input  logic [31:0] load_address,
    input  logic [7:0]  load_byte
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    count;
    logic [31:0]   addr_q;
    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] base;
    logic [31:0]   word;
    logic          unused_bits;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    end

    // Loads keep working in every state; the store itself is never cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && load_en)
            mem[load_address[AW-1:0]] <= load_byte;
    end

    // Word base is aligned down; the AW-bit sums wrap modulo MEM_BYTES.
    assign base = addr_q[AW-1:0] & ~AW'(3);
    assign word = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]};

    assign req_ready   = (state == IDLE);
    assign unused_bits = ^{addr_q, load_address};

`ifdef ADDR_ERR_EN
    logic fault;
    logic err_q;

    assign fault      = (addr_q[1:0] != 2'b00) || (addr_q > 32'(MEM_BYTES - 4));
    assign resp_error = err_q;
`else
    assign resp_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            count            <= 4'd0;
            addr_q           <= 32'd0;
            resp_valid       <= 1'b0;
            resp_instruction <= 32'd0;
`ifdef ADDR_ERR_EN
            err_q            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_address;
                        count  <= 4'(WAIT_STATES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
`ifdef ADDR_ERR_EN
                        resp_instruction <= fault ? 32'h0000_0000 : word;
                        err_q            <= fault;
`else
                        resp_instruction <= word;
`endif
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - directed bench for inst_mem_responder (WAIT_STATES=1 and WAIT_STATES=0 instances)
// Build option: ADDR_ERR_EN selects the fault-flag expectations.
module tb_inst_mem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        load_en;
    logic [31:0] load_address;
    logic [7:0]  load_byte;

    logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_error_a;
    logic [31:0] req_address_a, resp_instruction_a;
    logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_error_b;
    logic [31:0] req_address_b, resp_instruction_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    inst_mem_responder #(.MEM_BYTES(64), .WAIT_STATES(1)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_address(req_address_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_instruction(resp_instruction_a), .resp_error(resp_error_a),
        .load_en(load_en), .load_address(load_address), .load_byte(load_byte)
    );

    inst_mem_responder #(.MEM_BYTES(64), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_address(req_address_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_instruction(resp_instruction_b), .resp_error(resp_error_b),
        .load_en(load_en), .load_address(load_address), .load_byte(load_byte)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] b);
        load_en      = 1'b1;
        load_address = a;
        load_byte    = b;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    // Issue a request on dut_a and return the number of falling edges until resp_valid.
    task automatic issue_a(input logic [31:0] a, output int cyc);
        req_valid_a   = 1'b1;
        req_address_a = a;
        cyc = 0;
        @(negedge clock);
        cyc++;
        req_valid_a   = 1'b0;
        req_address_a = 32'hFFFF_FFFF;
        while (!resp_valid_a && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic read_a(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_instr, input logic exp_err);
        int cyc;
        issue_a(a, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        check({tag, "_instr"}, resp_instruction_a, exp_instr);
        check({tag, "_err"}, {31'd0, resp_error_a}, {31'd0, exp_err});
        @(negedge clock);
        check({tag, "_done"}, {31'd0, resp_valid_a}, 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        reset = 1'b1;
        load_en = 1'b0; load_address = 32'd0; load_byte = 8'd0;
        req_valid_a = 1'b0; req_address_a = 32'd0; resp_ready_a = 1'b1;
        req_valid_b = 1'b0; req_address_b = 32'd0; resp_ready_b = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        check("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid_a}, 32'd0);
        check("rst_instr", resp_instruction_a, 32'd0);
        check("rst_err", {31'd0, resp_error_a}, 32'd0);

        load(0, 8'h20); load(1, 8'h08); load(2, 8'h00); load(3, 8'h05);
        load(4, 8'hAC); load(5, 8'h09); load(6, 8'h00); load(7, 8'h04);

        // Basic fetch with edge-by-edge timing.
        req_valid_a = 1'b1; req_address_a = 32'd0;
        @(negedge clock);
        req_valid_a = 1'b0;
        check("w0_after_k", {31'd0, resp_valid_a}, 32'd0);
        check("w0_busy", {31'd0, req_ready_a}, 32'd0);
        @(negedge clock);
        check("w0_after_k1", {31'd0, resp_valid_a}, 32'd0);
        @(negedge clock);
        check("w0_after_k2", {31'd0, resp_valid_a}, 32'd1);
        check("w0_instr", resp_instruction_a, 32'h2008_0005);
        @(negedge clock);
        check("w0_idle_valid", {31'd0, resp_valid_a}, 32'd0);
        check("w0_idle_ready", {31'd0, req_ready_a}, 32'd1);
        check("w0_instr_kept", resp_instruction_a, 32'h2008_0005);

        read_a("w4", 32'd4, 32'hAC09_0004, 1'b0);

        // Zero wait states with a stalled response channel.
        req_valid_b = 1'b1; req_address_b = 32'd4;
        @(negedge clock);
        req_valid_b = 1'b0; req_address_b = 32'd0;
        check("b_after_k", {31'd0, resp_valid_b}, 32'd0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_hold%0d_valid", i), {31'd0, resp_valid_b}, 32'd1);
            check($sformatf("b_hold%0d_instr", i), resp_instruction_b, 32'hAC09_0004);
            if (i < 2) @(negedge clock);
        end
        resp_ready_b = 1'b1;
        @(negedge clock);
        resp_ready_b = 1'b0;
        check("b_done_valid", {31'd0, resp_valid_b}, 32'd0);
        check("b_done_ready", {31'd0, req_ready_b}, 32'd1);

        // Reset while in WAIT drops the request.
        req_valid_a = 1'b1; req_address_a = 32'd4;
        @(negedge clock);
        req_valid_a = 1'b0;
        reset = 1'b1;
        load_en = 1'b1; load_address = 32'd4; load_byte = 8'h55;
        @(negedge clock);
        reset = 1'b0; load_en = 1'b0;
        check("rstw_ready", {31'd0, req_ready_a}, 32'd1);
        check("rstw_valid", {31'd0, resp_valid_a}, 32'd0);
        check("rstw_instr", resp_instruction_a, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid_a) pulses++;
        end
        check("rstw_no_pulse", 32'(pulses), 32'd0);
        read_a("rstw_store", 32'd4, 32'hAC09_0004, 1'b0);

`ifdef ADDR_ERR_EN
        read_a("err_a2", 32'd2, 32'h0000_0000, 1'b1);
        read_a("err_a64", 32'd64, 32'h0000_0000, 1'b1);
        read_a("err_a60", 32'd60, 32'h0000_0000, 1'b0);
`else
        read_a("wrap_a66", 32'd66, 32'h2008_0005, 1'b0);
        read_a("wrap_a7", 32'd7, 32'hAC09_0004, 1'b0);
`endif

        // Load to byte 3 on the same edge that captures word 0.
        req_valid_a = 1'b1; req_address_a = 32'd0;
        @(negedge clock);
        req_valid_a = 1'b0;
        @(negedge clock);
        load_en = 1'b1; load_address = 32'd3; load_byte = 8'hFF;
        @(negedge clock);
        load_en = 1'b0;
        check("same_edge_valid", {31'd0, resp_valid_a}, 32'd1);
        check("same_edge_old", resp_instruction_a, 32'h2008_0005);
        @(negedge clock);
        read_a("after_load", 32'd0, 32'h2008_00FF, 1'b0);

        issue_a(32'd4, cyc);
        check("final_latency", 32'(cyc), 32'd3);
        check("final_instr", resp_instruction_a, 32'hAC09_0004);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
